// File: rtl/card_sprite_reader_pkg.sv
// Shared constants, types and the colour merge rule for the card sprite reader.
package card_sprite_reader_pkg;

  localparam int CARD_W  = 16;
  localparam int CARD_H  = 32;
  localparam int ADDR_W  = 9;
  localparam int COLOR_W = 3;
  localparam int X_W     = 8;
  localparam int Y_W     = 8;
  localparam int COL_W   = $clog2(CARD_W);
  localparam int ROW_W   = $clog2(CARD_H);

  typedef logic [COLOR_W-1:0] color_t;

  localparam color_t TRANSP     = 3'b000;
  localparam color_t BACK_COLOR = 3'b001;

  // One pipeline slot: pixel qualifier, rectangle hit, face-down flag and background.
  typedef struct packed {
    logic   valid;
    logic   hit;
    logic   face_down;
    color_t bg;
  } card_pipe_t;

  // Final colour for a valid pixel: background outside the card, solid back
  // colour when face down, otherwise the RAM image with TRANSP showing background.
  function automatic color_t merge_pixel(input card_pipe_t p, input color_t ram);
    color_t c;
    if (!p.hit)              c = p.bg;
    else if (p.face_down)    c = BACK_COLOR;
    else if (ram == TRANSP)  c = p.bg;
    else                     c = ram;
    return c;
  endfunction

endpackage

// File: rtl/card_sprite_reader_if.sv
// Pixel stream, card placement, card RAM read port and merged pixel output.
interface card_sprite_reader_if;
  import card_sprite_reader_pkg::*;

  logic             frame_start;
  logic             px_valid;
  logic [X_W-1:0]   px_x;
  logic [Y_W-1:0]   px_y;
  color_t           bg_color;
  logic [X_W-1:0]   card_x;
  logic [Y_W-1:0]   card_y;
  logic             card_visible;
  logic             face_down;
  logic             re;
  logic [ADDR_W-1:0] r_addr;
  color_t           ram_data;
  logic             px_out_valid;
  color_t           px_out;

  modport slave (
    input  frame_start, px_valid, px_x, px_y, bg_color,
    input  card_x, card_y, card_visible, face_down, ram_data,
    output re, r_addr, px_out_valid, px_out
  );

  modport master (
    output frame_start, px_valid, px_x, px_y, bg_color,
    output card_x, card_y, card_visible, face_down, ram_data,
    input  re, r_addr, px_out_valid, px_out
  );

endinterface

// File: rtl/card_sprite_reader_hit_addr.sv
// Combinational rectangle test and row-major card RAM address for one card.
module card_sprite_reader_hit_addr
  import card_sprite_reader_pkg::*;
(
  input  logic              px_valid_i,
  input  logic [X_W-1:0]    px_x_i,
  input  logic [Y_W-1:0]    px_y_i,
  input  logic              card_vis_i,
  input  logic [X_W-1:0]    card_x_i,
  input  logic [Y_W-1:0]    card_y_i,
  output logic              hit_o,
  output logic [ADDR_W-1:0] addr_o
);

  // Right/bottom bounds carry one extra bit so a card hanging off the edge clips instead of wrapping.
  logic [X_W:0]     x_end;
  logic [Y_W:0]     y_end;
  logic             in_x;
  logic             in_y;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;

  assign x_end = {1'b0, card_x_i} + (X_W+1)'(CARD_W);
  assign y_end = {1'b0, card_y_i} + (Y_W+1)'(CARD_H);

  assign in_x = (px_x_i >= card_x_i) && ({1'b0, px_x_i} < x_end);
  assign in_y = (px_y_i >= card_y_i) && ({1'b0, px_y_i} < y_end);

  assign hit_o = px_valid_i & card_vis_i & in_x & in_y;

  // Only the low bits of the offsets matter; inside the card they are the exact column/row.
  assign col = px_x_i[COL_W-1:0] - card_x_i[COL_W-1:0];
  assign row = px_y_i[ROW_W-1:0] - card_y_i[ROW_W-1:0];

  // Card dimensions are powers of two, so row*CARD_W+col is a plain concatenation.
  assign addr_o = {row, col};

endmodule

// File: rtl/card_sprite_reader.sv
// Card sprite read path: frame latch, hit/address stage, RAM access and colour merge.
module card_sprite_reader
  import card_sprite_reader_pkg::*;
(
  input  logic                 clock_i,
  input  logic                 reset_i,
  card_sprite_reader_if.slave  card_if
);

  logic              vis_q;
  logic              fd_q;
  logic [X_W-1:0]    cx_q;
  logic [Y_W-1:0]    cy_q;

  logic              hit;
  logic [ADDR_W-1:0] addr;

  card_pipe_t        s1_d;
  card_pipe_t        s1_q;
  card_pipe_t        s2_q;

  logic              re_q;
  logic [ADDR_W-1:0] raddr_q;

  logic              ov_q;
  color_t            px_d;
  color_t            px_q;

  card_sprite_reader_hit_addr u_hit_addr (
    .px_valid_i (card_if.px_valid),
    .px_x_i     (card_if.px_x),
    .px_y_i     (card_if.px_y),
    .card_vis_i (vis_q),
    .card_x_i   (cx_q),
    .card_y_i   (cy_q),
    .hit_o      (hit),
    .addr_o     (addr)
  );

  // Card placement latched once per frame; a pixel coincident with frame_start still sees the old values.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      vis_q <= 1'b0;
      fd_q  <= 1'b0;
      cx_q  <= '0;
      cy_q  <= '0;
    end else if (card_if.frame_start) begin
      vis_q <= card_if.card_visible;
      fd_q  <= card_if.face_down;
      cx_q  <= card_if.card_x;
      cy_q  <= card_if.card_y;
    end
  end

  // Stage 0 slot contents; bubbles carry a zero background so they leave nothing behind.
  always_comb begin
    s1_d           = '0;
    s1_d.valid     = card_if.px_valid;
    s1_d.hit       = hit;
    s1_d.face_down = fd_q;
    s1_d.bg        = card_if.px_valid ? card_if.bg_color : '0;
  end

  // Stage 1: issue the RAM read for image pixels; the address holds between hits.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      re_q    <= 1'b0;
      raddr_q <= '0;
      s1_q    <= '0;
    end else begin
      re_q <= hit & ~fd_q;
      if (hit) begin
        raddr_q <= addr;
      end
      s1_q <= s1_d;
    end
  end

  // Stage 2: wait for the RAM word while the slot travels alongside it.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      s2_q <= '0;
    end else begin
      s2_q <= s1_q;
    end
  end

  // Merge the returned word with the background; bubbles produce zero.
  always_comb begin
    px_d = '0;
    if (s2_q.valid) begin
      px_d = merge_pixel(s2_q, card_if.ram_data);
    end
  end

  // Stage 3: registered pixel output.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      ov_q <= 1'b0;
      px_q <= '0;
    end else begin
      ov_q <= s2_q.valid;
      px_q <= px_d;
    end
  end

  assign card_if.re           = re_q;
  assign card_if.r_addr       = raddr_q;
  assign card_if.px_out_valid = ov_q;
  assign card_if.px_out       = px_q;

endmodule

// File: tb/tb_card_sprite_reader.sv
// Bench for card_sprite_reader: per-cycle reference model, RAM model and scenario tasks.
module tb_card_sprite_reader;
  import card_sprite_reader_pkg::*;

  localparam int N = 4096;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  card_sprite_reader_if bus_if ();

  card_sprite_reader dut (
    .clock_i (clk),
    .reset_i (rst),
    .card_if (bus_if)
  );

  bit [2:0] mem [512];

  // Card RAM: synchronous read, data one cycle after RE.
  always @(posedge clk) begin
    if (bus_if.re) bus_if.ram_data <= mem[bus_if.r_addr];
  end

  // Expected and observed values indexed by sample cycle.
  bit       ex_ov [N];
  bit [2:0] ex_out[N];
  bit       ex_re [N];
  bit [8:0] ex_ra [N];
  logic       ob_ov [N];
  logic [2:0] ob_out[N];
  logic       ob_re [N];
  logic [8:0] ob_ra [N];

  int n = 0;
  int lcx = 0, lcy = 0;
  bit lvis = 0, lfd = 0;
  int mraddr = 0;
  int cfg_cx = 0, cfg_cy = 0;
  bit cfg_vis = 0, cfg_fd = 0;
  int total = 0, bad = 0;

  // One cycle: sample outputs, predict this input's effects, then drive it.
  task automatic step(input bit v, input int x, input int y, input bit [2:0] bg,
                      input bit fs, input bit r);
    bit       hit;
    int       a;
    bit [2:0] o;
    @(negedge clk);
    ob_ov[n]  = bus_if.px_out_valid;
    ob_out[n] = bus_if.px_out;
    ob_re[n]  = bus_if.re;
    ob_ra[n]  = bus_if.r_addr;
    if (r) begin
      lcx = 0; lcy = 0; lvis = 0; lfd = 0; mraddr = 0;
      for (int k = 1; k <= 3; k++) begin
        ex_ov[n+k] = 0; ex_out[n+k] = 0;
      end
      ex_re[n+1] = 0; ex_ra[n+1] = 0;
    end else begin
      hit = v && lvis && x >= lcx && x < lcx + CARD_W && y >= lcy && y < lcy + CARD_H;
      a = (y - lcy) * CARD_W + (x - lcx);
      if (hit) mraddr = a;
      ex_re[n+1] = hit && !lfd;
      ex_ra[n+1] = 9'(mraddr);
      if (!v) o = 0;
      else if (!hit) o = bg;
      else if (lfd) o = BACK_COLOR;
      else if (mem[a] == TRANSP) o = bg;
      else o = mem[a];
      ex_ov[n+3]  = v;
      ex_out[n+3] = o;
      if (fs) begin
        lcx = cfg_cx; lcy = cfg_cy; lvis = cfg_vis; lfd = cfg_fd;
      end
    end
    rst                 = r;
    bus_if.frame_start  = fs;
    bus_if.px_valid     = v;
    bus_if.px_x         = 8'(x);
    bus_if.px_y         = 8'(y);
    bus_if.bg_color     = v ? bg : 3'($urandom);
    bus_if.card_x       = fs ? 8'(cfg_cx) : 8'($urandom);
    bus_if.card_y       = fs ? 8'(cfg_cy) : 8'($urandom);
    bus_if.card_visible = fs ? cfg_vis : 1'($urandom);
    bus_if.face_down    = fs ? cfg_fd : 1'($urandom);
    n++;
  endtask

  task automatic latch_cfg(input int cx, input int cy, input bit vis, input bit fd);
    cfg_cx = cx; cfg_cy = cy; cfg_vis = vis; cfg_fd = fd;
    step(0, 0, 0, 0, 1, 0);
  endtask

  task automatic flush();
    for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    int s;
    s = n;
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    flush();
    total++;
    if ({ob_ov[s+1], ob_out[s+1], ob_re[s+1], ob_ra[s+1]} !== 14'd0) begin
      bad++;
      $display("FAIL reset_state got %b want 0", {ob_ov[s+1], ob_out[s+1], ob_re[s+1], ob_ra[s+1]});
    end
    for (int j = s; j < n; j++) begin
      total++;
      if ({ob_ov[j], ob_out[j], ob_re[j], ob_ra[j]} !== {ex_ov[j], ex_out[j], ex_re[j], ex_ra[j]}) begin
        bad++;
        $display("FAIL reset[%0d] got %b want %b", j, {ob_ov[j], ob_out[j], ob_re[j], ob_ra[j]},
                 {ex_ov[j], ex_out[j], ex_re[j], ex_ra[j]});
      end
    end
  endtask

  task automatic test_bg_only();
    int s, p;
    s = n;
    latch_cfg(100, 50, 0, 0);
    p = n;
    for (int k = 0; k < 10; k++) step(1, 100 + k, 50 + k, 3'(k + 2), 0, 0);
    flush();
    total++;
    if ({ob_ov[p+2], ob_ov[p+3], ob_out[p+3]} !== {1'b0, 1'b1, 3'd2}) begin
      bad++;
      $display("FAIL bg_latency got %b want 0_1_010", {ob_ov[p+2], ob_ov[p+3], ob_out[p+3]});
    end
    for (int j = s; j < n; j++) begin
      total++;
      if ({ob_ov[j], ob_out[j], ob_re[j], ob_ra[j]} !== {ex_ov[j], ex_out[j], ex_re[j], ex_ra[j]}) begin
        bad++;
        $display("FAIL bg_only[%0d] got %b want %b", j, {ob_ov[j], ob_out[j], ob_re[j], ob_ra[j]},
                 {ex_ov[j], ex_out[j], ex_re[j], ex_ra[j]});
      end
    end
  endtask

  task automatic test_addr_bounds();
    int s, p1, p2, p3, p4;
    s = n;
    latch_cfg(100, 50, 1, 0);
    p1 = n; step(1, 100, 50, 3'b010, 0, 0);
    p2 = n; step(1, 115, 81, 3'b010, 0, 0);
    p3 = n; step(1, 116, 50, 3'b110, 0, 0);
    p4 = n; step(1, 100, 82, 3'b011, 0, 0);
    flush();
    total++;
    if ({ob_re[p1+1], ob_ra[p1+1]} !== {1'b1, 9'd0}) begin
      bad++; $display("FAIL addr_first got %b want 1_0", {ob_re[p1+1], ob_ra[p1+1]});
    end
    total++;
    if ({ob_re[p2+1], ob_ra[p2+1]} !== {1'b1, 9'd511}) begin
      bad++; $display("FAIL addr_last got %b want 1_511", {ob_re[p2+1], ob_ra[p2+1]});
    end
    total++;
    if ({ob_re[p3+1], ob_out[p3+3]} !== {1'b0, 3'b110}) begin
      bad++; $display("FAIL right_miss got %b want 0_110", {ob_re[p3+1], ob_out[p3+3]});
    end
    total++;
    if ({ob_re[p4+1], ob_out[p4+3]} !== {1'b0, 3'b011}) begin
      bad++; $display("FAIL bottom_miss got %b want 0_011", {ob_re[p4+1], ob_out[p4+3]});
    end
    for (int j = s; j < n; j++) begin
      total++;
      if ({ob_ov[j], ob_out[j], ob_re[j], ob_ra[j]} !== {ex_ov[j], ex_out[j], ex_re[j], ex_ra[j]}) begin
        bad++;
        $display("FAIL addr[%0d] got %b want %b", j, {ob_ov[j], ob_out[j], ob_re[j], ob_ra[j]},
                 {ex_ov[j], ex_out[j], ex_re[j], ex_ra[j]});
      end
    end
  endtask

  task automatic test_ram_merge();
    int p1, p2;
    latch_cfg(100, 50, 1, 0);
    p1 = n; step(1, 101, 51, 3'b010, 0, 0);
    p2 = n; step(1, 102, 51, 3'b110, 0, 0);
    flush();
    total++;
    if ({ob_ov[p1+3], ob_out[p1+3]} !== {1'b1, 3'b101}) begin
      bad++; $display("FAIL ram_word got %b want 1_101", {ob_ov[p1+3], ob_out[p1+3]});
    end
    total++;
    if ({ob_ov[p2+3], ob_out[p2+3]} !== {1'b1, 3'b110}) begin
      bad++; $display("FAIL transparent got %b want 1_110", {ob_ov[p2+3], ob_out[p2+3]});
    end
  endtask

  task automatic test_face_down();
    int s, p1, p2;
    s = n;
    latch_cfg(100, 50, 1, 1);
    p1 = n; step(1, 105, 60, 3'b100, 0, 0);
    p2 = n; step(1, 50, 10, 3'b111, 0, 0);
    flush();
    total++;
    if ({ob_re[p1+1], ob_out[p1+3]} !== {1'b0, BACK_COLOR}) begin
      bad++; $display("FAIL face_down_in got %b want 0_001", {ob_re[p1+1], ob_out[p1+3]});
    end
    total++;
    if ({ob_re[p2+1], ob_out[p2+3]} !== {1'b0, 3'b111}) begin
      bad++; $display("FAIL face_down_out got %b want 0_111", {ob_re[p2+1], ob_out[p2+3]});
    end
    for (int j = s; j < n; j++) begin
      total++;
      if ({ob_ov[j], ob_out[j], ob_re[j], ob_ra[j]} !== {ex_ov[j], ex_out[j], ex_re[j], ex_ra[j]}) begin
        bad++;
        $display("FAIL face_down[%0d] got %b want %b", j, {ob_ov[j], ob_out[j], ob_re[j], ob_ra[j]},
                 {ex_ov[j], ex_out[j], ex_re[j], ex_ra[j]});
      end
    end
  endtask

  task automatic test_edge_clip();
    int s, p1, p2, pm;
    s = n;
    latch_cfg(250, 230, 1, 0);
    p1 = n; step(1, 255, 235, 3'b010, 0, 0);
    p2 = n; step(1, 255, 239, 3'b010, 0, 0);
    pm = n;
    for (int k = 0; k < 4; k++) step(1, k, 235, 3'b011, 0, 0);
    for (int k = 0; k < 4; k++) step(1, 252, k, 3'b011, 0, 0);
    flush();
    total++;
    if ({ob_re[p1+1], ob_ra[p1+1]} !== {1'b1, 9'd85}) begin
      bad++; $display("FAIL clip_x255 got %b want 1_85", {ob_re[p1+1], ob_ra[p1+1]});
    end
    total++;
    if ({ob_re[p2+1], ob_ra[p2+1]} !== {1'b1, 9'd149}) begin
      bad++; $display("FAIL clip_y239 got %b want 1_149", {ob_re[p2+1], ob_ra[p2+1]});
    end
    for (int k = 1; k <= 8; k++) begin
      total++;
      if ({ob_re[pm+k], ob_out[pm+k+2]} !== {1'b0, 3'b011}) begin
        bad++; $display("FAIL no_wrap[%0d] got %b want 0_011", k, {ob_re[pm+k], ob_out[pm+k+2]});
      end
    end
    for (int j = s; j < n; j++) begin
      total++;
      if ({ob_ov[j], ob_out[j], ob_re[j], ob_ra[j]} !== {ex_ov[j], ex_out[j], ex_re[j], ex_ra[j]}) begin
        bad++;
        $display("FAIL edge[%0d] got %b want %b", j, {ob_ov[j], ob_out[j], ob_re[j], ob_ra[j]},
                 {ex_ov[j], ex_out[j], ex_re[j], ex_ra[j]});
      end
    end
  endtask

  task automatic test_frame_latch();
    int p1, p2, p3;
    latch_cfg(100, 50, 1, 0);
    cfg_cx = 0; cfg_cy = 50; cfg_vis = 1; cfg_fd = 0;
    p1 = n; step(1, 100, 50, 3'b010, 1, 0);
    p2 = n; step(1, 100, 50, 3'b010, 0, 0);
    p3 = n; step(1, 5, 50, 3'b010, 0, 0);
    flush();
    total++;
    if ({ob_re[p1+1], ob_ra[p1+1]} !== {1'b1, 9'd0}) begin
      bad++; $display("FAIL latch_old got %b want 1_0", {ob_re[p1+1], ob_ra[p1+1]});
    end
    total++;
    if ({ob_re[p2+1], ob_out[p2+3]} !== {1'b0, 3'b010}) begin
      bad++; $display("FAIL latch_new_miss got %b want 0_010", {ob_re[p2+1], ob_out[p2+3]});
    end
    total++;
    if ({ob_re[p3+1], ob_ra[p3+1]} !== {1'b1, 9'd5}) begin
      bad++; $display("FAIL latch_new_hit got %b want 1_5", {ob_re[p3+1], ob_ra[p3+1]});
    end
  endtask

  task automatic test_reset_inflight();
    int s, pr, pn;
    s = n;
    latch_cfg(100, 50, 1, 0);
    for (int k = 0; k < 3; k++) step(1, 101 + k, 51, 3'b110, 0, 0);
    pr = n; step(0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 0, 0);
    pn = n; step(1, 101, 51, 3'b100, 0, 0);
    flush();
    for (int k = 1; k <= 4; k++) begin
      total++;
      if ({ob_ov[pr+k], ob_out[pr+k]} !== 4'd0) begin
        bad++; $display("FAIL rst_flush[%0d] got %b want 0", k, {ob_ov[pr+k], ob_out[pr+k]});
      end
    end
    total++;
    if ({ob_ov[pn+3], ob_out[pn+3], ob_re[pn+1]} !== {1'b1, 3'b100, 1'b0}) begin
      bad++; $display("FAIL rst_hidden got %b want 1_100_0", {ob_ov[pn+3], ob_out[pn+3], ob_re[pn+1]});
    end
    for (int j = s; j < n; j++) begin
      total++;
      if ({ob_ov[j], ob_out[j], ob_re[j], ob_ra[j]} !== {ex_ov[j], ex_out[j], ex_re[j], ex_ra[j]}) begin
        bad++;
        $display("FAIL rst_inflight[%0d] got %b want %b", j, {ob_ov[j], ob_out[j], ob_re[j], ob_ra[j]},
                 {ex_ov[j], ex_out[j], ex_re[j], ex_ra[j]});
      end
    end
  endtask

  task automatic test_random();
    int s, x, y;
    s = n;
    for (int f = 0; f < 6; f++) begin
      cfg_cx  = $urandom_range(0, 255);
      cfg_cy  = $urandom_range(0, 239);
      cfg_vis = ($urandom_range(0, 9) != 0);
      cfg_fd  = ($urandom_range(0, 4) == 0);
      step(1'($urandom), $urandom_range(0, 255), $urandom_range(0, 239), 3'($urandom), 1, 0);
      for (int k = 0; k < 150; k++) begin
        x = (cfg_cx + $urandom_range(0, 21) - 3) & 255;
        y = (cfg_cy + $urandom_range(0, 37) - 3) & 255;
        step($urandom_range(0, 9) < 7, x, y, 3'($urandom), 0, 0);
      end
    end
    flush();
    for (int j = s; j < n; j++) begin
      total++;
      if ({ob_ov[j], ob_out[j], ob_re[j], ob_ra[j]} !== {ex_ov[j], ex_out[j], ex_re[j], ex_ra[j]}) begin
        bad++;
        $display("FAIL random[%0d] got %b want %b", j, {ob_ov[j], ob_out[j], ob_re[j], ob_ra[j]},
                 {ex_ov[j], ex_out[j], ex_re[j], ex_ra[j]});
      end
    end
  endtask

  initial begin
    bus_if.frame_start  = 0;
    bus_if.px_valid     = 0;
    bus_if.px_x         = 0;
    bus_if.px_y         = 0;
    bus_if.bg_color     = 0;
    bus_if.card_x       = 0;
    bus_if.card_y       = 0;
    bus_if.card_visible = 0;
    bus_if.face_down    = 0;
    for (int i = 0; i < 512; i++) mem[i] = 3'($urandom);
    mem[17] = 3'b101;
    mem[18] = TRANSP;

    test_reset();
    test_bg_only();
    test_addr_bounds();
    test_ram_merge();
    test_face_down();
    test_edge_clip();
    test_frame_latch();
    test_reset_inflight();
    test_random();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
